clk_gate_requester: RTL

- Consumer-side companion to the clock gating FSM: sits between a work source and a gated load.
- Converts work arrivals into the clock request (drives the FSM's trig) and waits until the gated clock is live.
- Issues one load_start per queued item and drops the request after an idle timeout.
- Runs on the free-running clock. Its clk_en input is the FSM's combinational enable_clk output.

---
 rtl/clk_gate_requester.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/clk_gate_requester.sv
// clk_gate_requester: turns work arrivals into a clock request for the gating
// FSM. Once the gated clock is live it starts the queued items one at a time,
// and it releases the request after an idle timeout.
module clk_gate_requester #(
  parameter int IDLE_TIMEOUT = 4,
  parameter int CNT_W        = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             work_valid,
  output logic             work_ready,
  input  logic             done,
  input  logic             clk_en,
  output logic             clk_req,
  output logic             load_start,
  output logic [CNT_W-1:0] pending,
  output logic [1:0]       state,
  output logic [15:0]      wake_cycles
);

  typedef enum logic [1:0] {
    S_OFF   = 2'b00,
    S_WAKE  = 2'b01,
    S_RUN   = 2'b11,
    S_DRAIN = 2'b10
  } state_t;

  localparam int              IDLE_W    = (IDLE_TIMEOUT > 1) ? $clog2(IDLE_TIMEOUT) : 1;
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0]  PEND_MAX  = '1;

  state_t            r_state;
  state_t            w_state_next;
  logic              r_in_flight;
  logic              r_clk_en_q;
  logic              r_load_start;
  logic [CNT_W-1:0]  r_pending;
  logic [IDLE_W-1:0] r_idle;
  logic [15:0]       r_wake_cycles;

  logic w_accept;
  logic w_done;
  logic w_live;
  logic w_has_pend;
  logic w_idle_expire;
  logic w_load_go;

  assign work_ready    = (r_pending != PEND_MAX);
  assign w_accept      = work_valid & work_ready;
  // done without an item in flight carries no meaning and is dropped
  assign w_done        = done & r_in_flight;
  // the FSM raises its enable one cycle before the gate actually opens
  assign w_live        = clk_en & r_clk_en_q;
  assign w_has_pend    = (r_pending != '0);
  assign w_idle_expire = !w_accept && !w_has_pend && (r_idle == IDLE_LAST);

  // Start an item only if the next cycle is still RUN. Because load_start is
  // registered, this keeps the pulse from landing after a DRAIN or WAKE exit.
  assign w_load_go = (r_state == S_RUN) && (w_state_next == S_RUN) &&
                     !r_in_flight && w_has_pend;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_OFF;
    end else begin
      r_state <= w_state_next;
    end
  end

  // next-state decode
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_OFF: begin
        if (w_accept || w_has_pend) begin
          w_state_next = S_WAKE;
        end
      end
      S_WAKE: begin
        if (w_live) begin
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (!clk_en) begin
          w_state_next = S_WAKE;
        end else if (w_idle_expire) begin
          w_state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (w_accept) begin
          w_state_next = S_WAKE;
        end else if (!clk_en) begin
          w_state_next = S_OFF;
        end
      end
      default: w_state_next = S_OFF;
    endcase
  end

  // output decode
  always_comb begin
    clk_req     = (r_state == S_WAKE) || (r_state == S_RUN);
    state       = r_state;
    load_start  = r_load_start;
    pending     = r_pending;
    wake_cycles = r_wake_cycles;
  end

  // pending-item counter: accept and done in the same cycle cancel out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= '0;
    end else begin
      case ({w_accept, w_done})
        2'b10:   r_pending <= r_pending + 1'b1;
        2'b01:   r_pending <= r_pending - 1'b1;
        default: r_pending <= r_pending;
      endcase
    end
  end

  // single in-flight item tracking and registered start pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_in_flight  <= 1'b0;
      r_load_start <= 1'b0;
    end else begin
      r_load_start <= w_load_go;
      if (w_load_go) begin
        r_in_flight <= 1'b1;
      end else if (w_done) begin
        r_in_flight <= 1'b0;
      end
    end
  end

  // idle counter, only advancing while RUN persists with nothing queued
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idle <= '0;
    end else if ((r_state != S_RUN) || (w_state_next != S_RUN) ||
                 w_accept || w_has_pend) begin
      r_idle <= '0;
    end else begin
      r_idle <= r_idle + 1'b1;
    end
  end

  // enable history and saturating wake-time statistic
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_clk_en_q    <= 1'b0;
      r_wake_cycles <= '0;
    end else begin
      r_clk_en_q <= clk_en;
      if ((r_state == S_WAKE) && (r_wake_cycles != '1)) begin
        r_wake_cycles <= r_wake_cycles + 16'd1;
      end
    end
  end

endmodule
